// File: rtl/register_file_march_bist_ctrl.sv
// March C- BIST sequencer for one 1R1W latch register file behind its BIST wrapper.
// Drives the wrapper test port one op per cycle and checks Q_T one cycle after each read.
// The first mismatch (address and march element) is held until the next start or reset.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start_i            start a run (accepted in IDLE or DONE only)
//   busy_o, done_o     run in progress (RUN/DRAIN) / run finished (held)
//   fail_o             sticky mismatch flag for the current run
//   fail_addr_o        address of the first mismatch
//   fail_elem_o        march element (0..5) of the first mismatch
//   BIST               wrapper mux select, 1 while busy_o
//   CSN_T, WEN_T       test chip select (active-low), 0 = write / 1 = read
//   A_T, D_T           test address and write data
//   Q_T                test read data, valid one cycle after the read op
module register_file_march_bist_ctrl #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WORDS  = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fail_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [2:0]            fail_elem_o,
    output logic                  BIST,
    output logic                  CSN_T,
    output logic                  WEN_T,
    output logic [ADDR_WIDTH-1:0] A_T,
    output logic [DATA_WIDTH-1:0] D_T,
    input  logic [DATA_WIDTH-1:0] Q_T
);

    localparam int unsigned           ELEM_W    = 3;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [ELEM_W-1:0]     ELEM_LAST = 3'd5;
    localparam logic [DATA_WIDTH-1:0] WORD_ONES = '1;
    localparam logic [DATA_WIDTH-1:0] WORD_ZERO = '0;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    // March C- element table: M0 up(w0) M1 up(r0,w1) M2 up(r1,w0)
    // M3 down(r0,w1) M4 down(r1,w0) M5 up(r0)
    function automatic logic is_two_op(input logic [ELEM_W-1:0] e);
        return (e >= 3'd1) && (e <= 3'd4);
    endfunction

    function automatic logic is_down(input logic [ELEM_W-1:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic is_read(input logic [ELEM_W-1:0] e, input logic ph);
        return (e == ELEM_LAST) || (is_two_op(e) && !ph);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] read_val(input logic [ELEM_W-1:0] e);
        return ((e == 3'd2) || (e == 3'd4)) ? WORD_ONES : WORD_ZERO;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] write_val(input logic [ELEM_W-1:0] e);
        return ((e == 3'd1) || (e == 3'd3)) ? WORD_ONES : WORD_ZERO;
    endfunction

    state_e                  state_q, state_d;
    logic [ELEM_W-1:0]       elem_q, elem_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    phase_q, phase_d;

    logic                    bist_q, bist_d;
    logic                    csn_q, csn_d;
    logic                    wen_q, wen_d;
    logic [ADDR_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    fail_q, fail_d;
    logic [ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
    logic [ELEM_W-1:0]       fail_elem_q, fail_elem_d;

    logic                    chk_vld_q, chk_vld_d;
    logic [DATA_WIDTH-1:0]   chk_exp_q, chk_exp_d;
    logic [ADDR_WIDTH-1:0]   chk_addr_q, chk_addr_d;
    logic [ELEM_W-1:0]       chk_elem_q, chk_elem_d;

    logic                    start_ok;
    logic                    elem_end;
    logic [ELEM_W-1:0]       elem_nxt;

    // elem_q/addr_q/phase_q always describe the op currently on the test port
    assign start_ok = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i;
    assign elem_end = is_down(elem_q) ? (addr_q == '0) : (addr_q == ADDR_LAST);
    assign elem_nxt = elem_q + 3'd1;

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            elem_q      <= '0;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            bist_q      <= 1'b0;
            csn_q       <= 1'b1;
            wen_q       <= 1'b1;
            a_q         <= '0;
            dat_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            chk_vld_q   <= 1'b0;
            chk_exp_q   <= '0;
            chk_addr_q  <= '0;
            chk_elem_q  <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            bist_q      <= bist_d;
            csn_q       <= csn_d;
            wen_q       <= wen_d;
            a_q         <= a_d;
            dat_q       <= dat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            chk_vld_q   <= chk_vld_d;
            chk_exp_q   <= chk_exp_d;
            chk_addr_q  <= chk_addr_d;
            chk_elem_q  <= chk_elem_d;
        end
    end

    // Next state and march sequencing; address bounds compared explicitly, no wrap
    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    elem_d  = '0;
                    addr_d  = '0;
                    phase_d = 1'b0;
                end
            end
            S_RUN: begin
                if (is_two_op(elem_q) && !phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if ((elem_q == ELEM_LAST) && (addr_q == ADDR_LAST)) begin
                        state_d = S_DRAIN;
                    end else if (elem_end) begin
                        elem_d = elem_nxt;
                        addr_d = is_down(elem_nxt) ? ADDR_LAST : '0;
                    end else if (is_down(elem_q)) begin
                        addr_d = addr_q - 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_DRAIN: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output, read-check pipeline and fail capture
    always_comb begin
        bist_d      = 1'b0;
        csn_d       = 1'b1;
        wen_d       = 1'b1;
        a_d         = '0;
        dat_d       = '0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;

        case (state_d)
            S_RUN: begin
                bist_d = 1'b1;
                busy_d = 1'b1;
                csn_d  = 1'b0;
                wen_d  = is_read(elem_d, phase_d);
                a_d    = addr_d;
                dat_d  = is_read(elem_d, phase_d) ? WORD_ZERO : write_val(elem_d);
            end
            S_DRAIN: begin
                bist_d = 1'b1;
                busy_d = 1'b1;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase

        // Read op on the port now; its data returns next cycle
        chk_vld_d  = (state_q == S_RUN) && is_read(elem_q, phase_q);
        chk_exp_d  = read_val(elem_q);
        chk_addr_d = addr_q;
        chk_elem_d = elem_q;

        if (start_ok) begin
            fail_d      = 1'b0;
            fail_addr_d = '0;
            fail_elem_d = '0;
        end else if (chk_vld_q && (Q_T != chk_exp_q) && !fail_q) begin
            fail_d      = 1'b1;
            fail_addr_d = chk_addr_q;
            fail_elem_d = chk_elem_q;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign fail_o      = fail_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_elem_o = fail_elem_q;
    assign BIST        = bist_q;
    assign CSN_T       = csn_q;
    assign WEN_T       = wen_q;
    assign A_T         = a_q;
    assign D_T         = dat_q;

endmodule

// File: tb/tb_register_file_march_bist_ctrl.sv
// Bench for register_file_march_bist_ctrl: two instances (N=32 and N=20), each behind
// a behavioural register file with injectable stuck-at and lost-write faults.
module tb_register_file_march_bist_ctrl;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int          NW [2] = '{32, 20};

    typedef struct packed {
        logic          we_n;
        logic [AW-1:0] ad;
        logic [DW-1:0] dt;
    } op_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]          rst;
    logic [1:0]          start;
    wire  [1:0]          busy, done, fail, bist, csn, wen;
    wire  [1:0][AW-1:0]  faddr, a;
    wire  [1:0][2:0]     felem;
    wire  [1:0][DW-1:0]  d;
    logic [1:0][DW-1:0]  q;

    int vectors = 0;
    int errors  = 0;

    // Fault configuration shared by both array models (only one runs at a time)
    int sa_addr  = -1;
    int sa_bit   = 0;
    int sa_val   = 0;
    int ign_addr = -1;
    int ign_elem = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        register_file_march_bist_ctrl #(
            .ADDR_WIDTH(AW),
            .DATA_WIDTH(DW),
            .NUM_WORDS ((g == 0) ? 32 : 20)
        ) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .start_i    (start[g]),
            .busy_o     (busy[g]),
            .done_o     (done[g]),
            .fail_o     (fail[g]),
            .fail_addr_o(faddr[g]),
            .fail_elem_o(felem[g]),
            .BIST       (bist[g]),
            .CSN_T      (csn[g]),
            .WEN_T      (wen[g]),
            .A_T        (a[g]),
            .D_T        (d[g]),
            .Q_T        (q[g])
        );
    end

    // Register-file models: synchronous write and read; the ign_elem-th prior write
    // count selects which write to ign_addr is lost (M0 write is count 0)
    logic [DW-1:0] mem  [2][32];
    int            wcnt [2][32];

    always @(posedge clk) begin : rf_model
        logic [DW-1:0] rd;
        for (int k = 0; k < 2; k++) begin
            if (!bist[k]) begin
                for (int i = 0; i < 32; i++) wcnt[k][i] <= 0;
            end else if (!csn[k]) begin
                if (!wen[k]) begin
                    if (!((int'(a[k]) == ign_addr) && (wcnt[k][a[k]] == ign_elem)))
                        mem[k][a[k]] <= d[k];
                    wcnt[k][a[k]] <= wcnt[k][a[k]] + 1;
                end else begin
                    rd = mem[k][a[k]];
                    if (int'(a[k]) == sa_addr) rd[sa_bit] = sa_val[0];
                    q[k] <= rd;
                end
            end
        end
    end

    function automatic int elem_addr(input int e, input int j, input int n);
        return ((e == 3) || (e == 4)) ? (n - 1 - j) : j;
    endfunction

    // Abstract March C- run over an array with the configured fault
    function automatic void march_ref(input int n, output bit f, output int fa, output int fe);
        logic [DW-1:0] m  [32];
        int            wc [32];
        logic [DW-1:0] rd, ex;
        f = 1'b0; fa = 0; fe = 0;
        for (int i = 0; i < 32; i++) begin m[i] = '0; wc[i] = 0; end
        for (int e = 0; e < 6; e++) begin
            for (int j = 0; j < n; j++) begin
                int adr;
                adr = elem_addr(e, j, n);
                if (e != 0) begin
                    ex = ((e == 2) || (e == 4)) ? '1 : '0;
                    rd = m[adr];
                    if (adr == sa_addr) rd[sa_bit] = sa_val[0];
                    if ((rd !== ex) && !f) begin f = 1'b1; fa = adr; fe = e; end
                end
                if (e != 5) begin
                    if (!((adr == ign_addr) && (wc[adr] == ign_elem)))
                        m[adr] = ((e == 1) || (e == 3)) ? '1 : '0;
                    wc[adr]++;
                end
            end
        end
    endfunction

    task automatic clear_faults();
        sa_addr  = -1;
        ign_addr = -1;
    endtask

    // One full run: op trace, busy/BIST window, done timing, fail result.
    // start is held high during op indices [hold_lo, hold_hi) to show it is ignored.
    task automatic run_check(input int k, input bit ef, input int efa, input int efe,
                             input int hold_lo, input int hold_hi, input string tag);
        op_t ops[$];
        int  n;
        n = NW[k];
        for (int e = 0; e < 6; e++)
            for (int j = 0; j < n; j++) begin
                logic [AW-1:0] ad;
                ad = AW'(elem_addr(e, j, n));
                if (e != 0) ops.push_back('{1'b1, ad, '0});
                if (e != 5) ops.push_back('{1'b0, ad, ((e == 1) || (e == 3)) ? '1 : '0});
            end

        @(negedge clk) start[k] = 1'b1;
        @(negedge clk) start[k] = 1'b0;
        vectors++;
        if (busy[k] !== 1'b1 || bist[k] !== 1'b1 || done[k] !== 1'b0 || fail[k] !== 1'b0 ||
            faddr[k] !== '0 || felem[k] !== '0) begin
            errors++;
            $display("FAIL %s start: busy=%b bist=%b done=%b fail=%b fa=%0d fe=%0d, want 1 1 0 0 0 0",
                     tag, busy[k], bist[k], done[k], fail[k], faddr[k], felem[k]);
        end

        for (int i = 0; i < ops.size(); i++) begin
            if (i > 0) @(negedge clk);
            start[k] = (i >= hold_lo) && (i < hold_hi);
            vectors++;
            if (csn[k] !== 1'b0 || busy[k] !== 1'b1 || bist[k] !== 1'b1 ||
                wen[k] !== ops[i].we_n || a[k] !== ops[i].ad ||
                (!ops[i].we_n && d[k] !== ops[i].dt)) begin
                errors++;
                $display("FAIL %s op%0d: csn=%b busy=%b bist=%b wen=%b a=%0d d=%h, want 0 1 1 %b %0d %h",
                         tag, i + 1, csn[k], busy[k], bist[k], wen[k], a[k], d[k],
                         ops[i].we_n, ops[i].ad, ops[i].dt);
            end
        end
        start[k] = 1'b0;

        @(negedge clk);
        vectors++;
        if (busy[k] !== 1'b1 || bist[k] !== 1'b1 || csn[k] !== 1'b1 || done[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s drain: busy=%b bist=%b csn=%b done=%b, want 1 1 1 0",
                     tag, busy[k], bist[k], csn[k], done[k]);
        end

        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++;
            if (done[k] !== 1'b1 || busy[k] !== 1'b0 || bist[k] !== 1'b0 || csn[k] !== 1'b1 ||
                fail[k] !== ef || (ef && (int'(faddr[k]) != efa || int'(felem[k]) != efe))) begin
                errors++;
                $display("FAIL %s done%0d: done=%b busy=%b bist=%b csn=%b fail=%b fa=%0d fe=%0d, want 1 0 0 1 %b %0d %0d",
                         tag, c, done[k], busy[k], bist[k], csn[k], fail[k], faddr[k], felem[k],
                         ef, efa, efe);
            end
        end
    endtask

    task automatic check_idle(input int k, input string tag);
        vectors++;
        if (busy[k] !== 1'b0 || done[k] !== 1'b0 || fail[k] !== 1'b0 || faddr[k] !== '0 ||
            felem[k] !== '0 || bist[k] !== 1'b0 || csn[k] !== 1'b1 || wen[k] !== 1'b1 ||
            a[k] !== '0 || d[k] !== '0) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b fail=%b fa=%0d fe=%0d bist=%b csn=%b wen=%b a=%0d d=%h, want idle reset values",
                     tag, busy[k], done[k], fail[k], faddr[k], felem[k], bist[k], csn[k],
                     wen[k], a[k], d[k]);
        end
    endtask

    task automatic test_reset();
        rst = 2'b11;
        start = 2'b00;
        repeat (3) @(negedge clk);
        check_idle(0, "reset_n32");
        check_idle(1, "reset_n20");
        rst = 2'b00;
        @(negedge clk);
        check_idle(0, "idle_n32");
    endtask

    task automatic test_fault_free();
        clear_faults();
        run_check(0, 1'b0, 0, 0, -1, -1, "fault_free_n32");
    endtask

    task automatic test_stuck_at1();
        clear_faults();
        sa_addr = 5; sa_bit = 3; sa_val = 1;
        run_check(0, 1'b1, 5, 1, -1, -1, "stuck1_a5b3");
        clear_faults();
    endtask

    task automatic test_lost_write();
        clear_faults();
        ign_addr = 9; ign_elem = 4;
        run_check(0, 1'b1, 9, 5, -1, -1, "lost_write_a9_m4");
        clear_faults();
    endtask

    task automatic test_start_handling();
        clear_faults();
        sa_addr = 7; sa_bit = 0; sa_val = 1;
        run_check(0, 1'b1, 7, 1, 50, 60, "start_held_midrun");
        clear_faults();
        run_check(0, 1'b0, 0, 0, -1, -1, "restart_from_done");
    endtask

    task automatic test_reset_midrun();
        clear_faults();
        sa_addr = 2; sa_bit = 17; sa_val = 1;
        @(negedge clk) start[0] = 1'b1;
        @(negedge clk) start[0] = 1'b0;
        repeat (3 * 32 + 5) @(negedge clk);
        vectors++;
        if (busy[0] !== 1'b1 || fail[0] !== 1'b1 || faddr[0] !== AW'(2)) begin
            errors++;
            $display("FAIL rst_mid_pre: busy=%b fail=%b fa=%0d, want 1 1 2", busy[0], fail[0], faddr[0]);
        end
        rst[0] = 1'b1;
        @(negedge clk);
        check_idle(0, "rst_mid_m2");
        rst[0] = 1'b0;
        @(negedge clk);
        check_idle(0, "rst_mid_after");
        clear_faults();
    endtask

    task automatic test_n20();
        clear_faults();
        run_check(1, 1'b0, 0, 0, -1, -1, "fault_free_n20");
        ign_addr = 19; ign_elem = 3;
        run_check(1, 1'b1, 19, 4, -1, -1, "lost_write_n20_a19_m3");
        clear_faults();
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int  k, kind;
            bit  f;
            int  fa, fe;
            k    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 3));
            clear_faults();
            case (kind)
                1, 2: begin
                    sa_addr = int'($urandom_range(0, NW[k] - 1));
                    sa_bit  = int'($urandom_range(0, DW - 1));
                    sa_val  = (kind == 1) ? 1 : 0;
                end
                3: begin
                    ign_addr = int'($urandom_range(0, NW[k] - 1));
                    ign_elem = int'($urandom_range(1, 4));
                end
                default: ;
            endcase
            march_ref(NW[k], f, fa, fe);
            run_check(k, f, fa, fe, -1, -1, $sformatf("random%0d_k%0d_kind%0d", r, k, kind));
        end
        clear_faults();
    endtask

    initial begin
        test_reset();
        test_fault_free();
        test_stuck_at1();
        test_lost_write();
        test_start_handling();
        test_reset_midrun();
        test_n20();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
